// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, divisor helper and frame length for the UART transmitter
package uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int FRAME_BITS = 10;
`endif

    // Rounded clocks-per-bit so the baud error is at most half a clock
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: DIV-cycle bit timer with clear, pulses bit_tick on the last cycle of each bit
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign bit_tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || !en || bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART byte serializer, LSB first; define UART_PARITY_EN to add an even-parity bit
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);

    if (DIV < 2) begin : g_div_check
        $error("uart_byte_tx: DIV must be at least 2");
    end

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       bit_tick;
    logic       accept;
`ifdef UART_PARITY_EN
    logic       par;
`endif

    assign accept = tx_valid && tx_ready;
    assign busy   = !tx_ready;

    // Clearing on accept gives the start bit its full DIV-cycle width
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state != IDLE),
        .clr      (accept),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            uart_tx  <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
`ifdef UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= START;
                    tx_ready <= 1'b0;
                    uart_tx  <= 1'b0;
                    shreg    <= tx_data;
                    bit_cnt  <= '0;
`ifdef UART_PARITY_EN
                    par      <= ^tx_data;
`endif
                end
                START: if (bit_tick) begin
                    state   <= DATA;
                    uart_tx <= shreg[0];
                    shreg   <= shreg >> 1;
                end
                DATA: if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        state   <= PARITY;
                        uart_tx <= par;
`else
                        state   <= STOP;
                        uart_tx <= 1'b1;
`endif
                    end else begin
                        uart_tx <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: if (bit_tick) begin
                    state   <= STOP;
                    uart_tx <= 1'b1;
                end
`endif
                STOP: if (bit_tick) begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed self-checking bench for uart_byte_tx at DIV=10
module tb_uart_byte_tx;

    localparam int DIV = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;

    int tests = 0;
    int fails = 0;

    uart_byte_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_tx  (uart_tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected line bits in time order: start, d0..d7, [parity], stop
    function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Samples FL negedges starting now (cycle 0 after the accept edge)
    task automatic capture(output logic [10:0] bits, output bit stable, output int busy_n);
        logic s [0:FL-1];
        busy_n = 0;
        for (int k = 0; k < FL; k++) begin
            if (k > 0) @(negedge clk);
            s[k] = uart_tx;
            if (busy === 1'b1) busy_n++;
        end
        bits   = '0;
        stable = 1'b1;
        for (int b = 0; b < NB; b++) begin
            bits[b] = s[b * DIV + DIV / 2];
            for (int j = 0; j < DIV; j++)
                if (s[b * DIV + j] !== bits[b]) stable = 1'b0;
        end
    endtask

    // Called at cycle FL-1; returns the cycle index of the next start bit
    task automatic wait_start(output int k);
        k = FL;
        @(negedge clk);
        while (uart_tx !== 1'b0 && k < FL + 50) begin
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({uart_tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL reset_hold: {uart_tx,tx_ready,busy}=%b required 110", {uart_tx, tx_ready, busy});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tests++;
            if ({uart_tx, tx_ready, busy} !== 3'b110) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: {uart_tx,tx_ready,busy}=%b required 110", i, {uart_tx, tx_ready, busy});
            end
        end
    endtask

    task automatic test_send_55;
        logic [10:0] bits;
        logic [10:0] exp;
        bit          stable;
        int          bn;
        exp = frame(8'h55);
        send_byte(8'h55);
        capture(bits, stable, bn);
        tests++;
        if (bits[NB-1:0] !== exp[NB-1:0]) begin
            fails++;
            $display("FAIL send_55 bits: got %b required %b", bits[NB-1:0], exp[NB-1:0]);
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL send_55 bit_width: line changed inside a bit period, got 0 required 1");
        end
        tests++;
        if (bn !== FL) begin
            fails++;
            $display("FAIL send_55 busy_cycles: got %0d required %0d", bn, FL);
        end
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL send_55 ready_last_cycle: got %b required 0", tx_ready);
        end
        @(negedge clk);
        tests++;
        if ({uart_tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL send_55 ready_return: {uart_tx,tx_ready,busy}=%b required 110", {uart_tx, tx_ready, busy});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (uart_tx !== 1'b1) begin
                fails++;
                $display("FAIL send_55 idle_after cycle %0d: uart_tx=%b required 1", i, uart_tx);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits;
        logic [10:0] exp;
        bit          stable;
        int          bn;
        int          k;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        capture(bits, stable, bn);
        exp = frame(8'h00);
        tests++;
        if (bits[NB-1:0] !== exp[NB-1:0] || !stable) begin
            fails++;
            $display("FAIL b2b first_00: got %b stable=%b required %b stable=1", bits[NB-1:0], stable, exp[NB-1:0]);
        end
        wait_start(k);
        tx_valid = 1'b0;
        tests++;
        if (k !== FL + 1) begin
            fails++;
            $display("FAIL b2b spacing: second start at cycle %0d required %0d", k, FL + 1);
        end
        capture(bits, stable, bn);
        exp = frame(8'hFF);
        tests++;
        if (bits[NB-1:0] !== exp[NB-1:0] || !stable) begin
            fails++;
            $display("FAIL b2b second_FF: got %b stable=%b required %b stable=1", bits[NB-1:0], stable, exp[NB-1:0]);
        end
    endtask

    task automatic test_hold_during_busy;
        logic [10:0] bits;
        logic [10:0] exp;
        bit          stable;
        int          bn;
        int          k;
        send_byte(8'hA5);
        fork
            capture(bits, stable, bn);
            begin
                repeat (10) @(negedge clk);
                tx_valid = 1'b1;
                for (int i = 10; i < FL - 1; i++) begin
                    tx_data = i[0] ? 8'h3C : 8'hC3;
                    @(negedge clk);
                end
                tx_data = 8'h3C;
            end
        join
        exp = frame(8'hA5);
        tests++;
        if (bits[NB-1:0] !== exp[NB-1:0] || !stable) begin
            fails++;
            $display("FAIL hold A5_frame: got %b stable=%b required %b stable=1", bits[NB-1:0], stable, exp[NB-1:0]);
        end
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold no_early_accept: tx_ready=%b required 0", tx_ready);
        end
        wait_start(k);
        tx_valid = 1'b0;
        tests++;
        if (k !== FL + 1) begin
            fails++;
            $display("FAIL hold 3C_start: start at cycle %0d required %0d", k, FL + 1);
        end
        capture(bits, stable, bn);
        exp = frame(8'h3C);
        tests++;
        if (bits[NB-1:0] !== exp[NB-1:0] || !stable) begin
            fails++;
            $display("FAIL hold 3C_frame: got %b stable=%b required %b stable=1", bits[NB-1:0], stable, exp[NB-1:0]);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] bits;
        logic [10:0] exp;
        bit          stable;
        int          bn;
        send_byte(8'h81);
        repeat (35) @(negedge clk);
        tests++;
        if (uart_tx !== 1'b0) begin
            fails++;
            $display("FAIL midreset d2_before: uart_tx=%b required 0", uart_tx);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({uart_tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL midreset async: {uart_tx,tx_ready,busy}=%b required 110", {uart_tx, tx_ready, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tests++;
            if ({uart_tx, tx_ready, busy} !== 3'b110) begin
                fails++;
                $display("FAIL midreset no_replay cycle %0d: {uart_tx,tx_ready,busy}=%b required 110", i, {uart_tx, tx_ready, busy});
            end
        end
        send_byte(8'h3C);
        capture(bits, stable, bn);
        exp = frame(8'h3C);
        tests++;
        if (bits[NB-1:0] !== exp[NB-1:0] || !stable) begin
            fails++;
            $display("FAIL midreset 3C_frame: got %b stable=%b required %b stable=1", bits[NB-1:0], stable, exp[NB-1:0]);
        end
        tests++;
        if (bn !== FL) begin
            fails++;
            $display("FAIL midreset busy_cycles: got %0d required %0d", bn, FL);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        logic [10:0] bits;
        bit          stable;
        int          bn;
        repeat (3) @(negedge clk);
        send_byte(8'h07);
        capture(bits, stable, bn);
        tests++;
        if (bits !== 11'b1_1_00000111_0 || !stable) begin
            fails++;
            $display("FAIL parity 07: got %b stable=%b required 11100000110 stable=1", bits, stable);
        end
        tests++;
        if (bn !== 110) begin
            fails++;
            $display("FAIL parity busy_cycles: got %0d required 110", bn);
        end
        repeat (3) @(negedge clk);
        send_byte(8'h03);
        capture(bits, stable, bn);
        tests++;
        if (bits !== 11'b1_0_00000011_0 || !stable) begin
            fails++;
            $display("FAIL parity 03: got %b stable=%b required 10000000110 stable=1", bits, stable);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_send_55;
        test_back_to_back;
        repeat (5) @(negedge clk);
        test_hold_during_busy;
        repeat (5) @(negedge clk);
        test_reset_mid_frame;
`ifdef UART_PARITY_EN
        test_parity;
`endif
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
